// File: rtl/seq_ripple_borrow_sub_pkg.sv
// Shared definitions for the multi-cycle arithmetic blocks: FSM state
// encoding, default geometry and the width-compatibility helpers.
package seq_ripple_borrow_sub_pkg;

    // Common three-phase handshake FSM used by the multi-cycle units.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } arith_state_e;

    // Default geometry of the library instance.
    localparam int DEFAULT_W     = 32;
    localparam int DEFAULT_CHUNK = 8;
    localparam int NCHUNK        = DEFAULT_W / DEFAULT_CHUNK;

    // A width split is legal only when the chunk tiles the word exactly.
    function automatic bit width_ok(input int w, input int chunk);
        return (chunk > 0) && (w >= chunk) && ((w % chunk) == 0);
    endfunction

    // Counter width able to address n slices (never zero bits wide).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_ripple_borrow_sub_chunk.sv
// Combinational CHUNK-bit ripple-borrow subtractor slice: d = x - y - bi.
module rbs_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bi,
    output logic [CHUNK-1:0] d,
    output logic             bo
);

    // Walk the borrow from LSB to MSB, one full-subtractor cell per bit.
    always_comb begin
        logic borrow;
        borrow = bi;
        d      = '0;
        for (int i = 0; i < CHUNK; i++) begin
            d[i]   = x[i] ^ y[i] ^ borrow;
            borrow = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & borrow);
        end
        bo = borrow;
    end

endmodule

// File: rtl/seq_ripple_borrow_sub.sv
// Multi-cycle ripple-borrow subtractor. One CHUNK-bit slice is resolved per
// cycle, LSB first, with the inter-slice borrow held in a register so the
// critical path is a single slice rather than the full word.
module seq_ripple_borrow_sub
    import seq_ripple_borrow_sub_pkg::*;
#(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    localparam int NSLICE = W / CHUNK;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    // Refuse to elaborate a split that does not tile the word.
    generate
        if (!width_ok(W, CHUNK)) begin : g_bad_width
            $error("seq_ripple_borrow_sub: W must be a non-zero multiple of CHUNK");
        end
    endgenerate

    arith_state_e      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              borrow_q, borrow_d;
    logic [W-1:0]      diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              ovf_q, ovf_d;

    // Operand slices, selected by the current slice index.
    logic [CHUNK-1:0]  a_slices [NSLICE];
    logic [CHUNK-1:0]  b_slices [NSLICE];
    logic [CHUNK-1:0]  cur_a, cur_b, cur_d;
    logic              cur_bo;
    logic [W-1:0]      diff_upd;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slices
            assign a_slices[gi] = a_q[gi*CHUNK +: CHUNK];
            assign b_slices[gi] = b_q[gi*CHUNK +: CHUNK];
            // Only the slice being resolved this cycle is overwritten.
            assign diff_upd[gi*CHUNK +: CHUNK] = (idx_q == IDX_W'(gi)) ? cur_d
                                                : diff_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign cur_a = a_slices[idx_q];
    assign cur_b = b_slices[idx_q];

    rbs_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x  (cur_a),
        .y  (cur_b),
        .bi (borrow_q),
        .d  (cur_d),
        .bo (cur_bo)
    );

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    idx_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                diff_d   = diff_upd;
                borrow_d = cur_bo;
                if (idx_q == LAST_IDX) begin
                    // Final slice: the outgoing borrow and the new sign bit
                    // complete the result flags.
                    bout_d  = cur_bo;
                    ovf_d   = (a_q[W-1] != b_q[W-1]) && (diff_upd[W-1] != a_q[W-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_ripple_borrow_sub.sv
// Self-checking bench for seq_ripple_borrow_sub (W=32, CHUNK=8).
module tb_seq_ripple_borrow_sub;

    localparam int W       = 32;
    localparam int CHUNK   = 8;
    localparam int LATENCY = W / CHUNK;
    localparam int BUDGET  = 50;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_ripple_borrow_sub #(
        .W     (W),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    // Reference: exact integer arithmetic on 64-bit values.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mbin, output logic [W-1:0] md,
                                  output logic mbo, output logic mov);
        longint ua, ub, r, sa, sb, rs;
        ua  = longint'(ma);
        ub  = longint'(mb);
        r   = ua - ub - longint'(mbin);
        md  = r[W-1:0];
        mbo = (r < 0);
        sa  = longint'($signed(ma));
        sb  = longint'($signed(mb));
        rs  = sa - sb - longint'(mbin);
        mov = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
    endfunction

    // Drive one operation, scramble the inputs after accept, wait for result.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                          output logic [W-1:0] rd, output logic rbo, output logic rov,
                          output int lat, output bit to);
        int n;
        to  = 1'b0;
        lat = 0;
        rd  = '0;
        rbo = 1'b0;
        rov = 1'b0;
        @(negedge clk);
        a = oa; b = ob; bin = obin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            to = 1'b1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
        while (!out_valid && lat < BUDGET) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) to = 1'b1;
        rd  = diff;
        rbo = bout;
        rov = ovf;
    endtask

    // Accept the pending result after a number of stall cycles.
    task automatic consume(input int stall);
        out_ready = 1'b0;
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        checks++;
        if (diff !== '0 || bout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: diff=%h bout=%b ovf=%b, required 0/0/0", diff, bout, ovf);
        end
        rst = 1'b0;
        $display("reset: in_ready=%b out_valid=%b diff=%h", in_ready, out_valid, diff);
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic         vbin [4];
        logic [W-1:0] rd, ed;
        logic         rbo, rov, ebo, eov;
        int           lat;
        bit           to;
        va[0] = 32'h0000_0100; vb[0] = 32'h1;           vbin[0] = 1'b0;
        va[1] = 32'h0;         vb[1] = 32'h1;           vbin[1] = 1'b0;
        va[2] = 32'h8000_0000; vb[2] = 32'h1;           vbin[2] = 1'b0;
        va[3] = 32'h1234_5678; vb[3] = 32'h1234_5678;   vbin[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vbin[i], rd, rbo, rov, lat, to);
            model(va[i], vb[i], vbin[i], ed, ebo, eov);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL directed%0d_timeout: no result within %0d cycles", i, BUDGET);
            end
            checks++;
            if (rd !== ed || rbo !== ebo || rov !== eov) begin
                errors++;
                $display("FAIL directed%0d_result: got diff=%h bout=%b ovf=%b, required %h/%b/%b",
                         i, rd, rbo, rov, ed, ebo, eov);
            end
            checks++;
            if (lat != LATENCY) begin
                errors++;
                $display("FAIL directed%0d_latency: got %0d, required %0d", i, lat, LATENCY);
            end
            consume(0);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed%0d_ready: in_ready=%b, required 1", i, in_ready);
            end
            $display("directed%0d: a=%h b=%h bin=%b diff=%h bout=%b ovf=%b lat=%0d",
                     i, va[i], vb[i], vbin[i], rd, rbo, rov, lat);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] oa, ob, rd, ed;
        logic         rbo, rov, ebo, eov;
        int           lat;
        bit           to;
        oa = $urandom; ob = $urandom;
        run_op(oa, ob, 1'b1, rd, rbo, rov, lat, to);
        model(oa, ob, 1'b1, ed, ebo, eov);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL stall_timeout: no result within %0d cycles", BUDGET);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== ed || bout !== ebo || ovf !== eov) begin
                errors++;
                $display("FAIL stall_hold%0d: out_valid=%b in_ready=%b diff=%h bout=%b ovf=%b, required 1/0/%h/%b/%b",
                         i, out_valid, in_ready, diff, bout, ovf, ed, ebo, eov);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        $display("stall: a=%h b=%h diff=%h held 5 cycles", oa, ob, ed);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] rd, ed;
        logic         rbo, rov, ebo, eov;
        int           lat, n;
        bit           to;
        run_op(32'h0000_1000, 32'h0000_0001, 1'b0, rd, rbo, rov, lat, to);
        model(32'h0000_1000, 32'h0000_0001, 1'b0, ed, ebo, eov);
        checks++;
        if (to || rd !== ed) begin
            errors++;
            $display("FAIL b2b_first: diff=%h timeout=%b, required %h/0", rd, to, ed);
        end
        // Second operation is presented while the first is still in DONE.
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; bin = 1'b1; in_valid = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_blocked: in_ready=%b during DONE, required 0", in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: in_ready=%b after accept, required 0", in_ready);
        end
        n = 0;
        while (!out_valid && n < BUDGET) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, ed, ebo, eov);
        checks++;
        if (n != LATENCY || diff !== ed || bout !== ebo || ovf !== eov) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d diff=%h bout=%b ovf=%b, required %0d/%h/%b/%b",
                     n, diff, bout, ovf, LATENCY, ed, ebo, eov);
        end
        $display("back_to_back: second diff=%h bout=%b lat=%0d", diff, bout, n);
        consume(0);
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] rd, ed;
        logic         rbo, rov, ebo, eov;
        int           lat;
        bit           to;
        @(negedge clk);
        a = 32'h1122_3344; b = 32'h0101_0101; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== '0 || bout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: out_valid=%b in_ready=%b diff=%h bout=%b ovf=%b, required 0/1/0/0/0",
                     out_valid, in_ready, diff, bout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd10, 32'd3, 1'b0, rd, rbo, rov, lat, to);
        model(32'd10, 32'd3, 1'b0, ed, ebo, eov);
        checks++;
        if (to || rd !== ed || rbo !== ebo || lat != LATENCY) begin
            errors++;
            $display("FAIL midrun_next: diff=%h bout=%b lat=%0d timeout=%b, required %h/%b/%0d/0",
                     rd, rbo, lat, to, ed, ebo, LATENCY);
        end
        $display("reset_mid_run: next op 10-3 diff=%h bout=%b", rd, rbo);
        consume(0);
    endtask

    task automatic test_random(input int n_vec);
        logic [W-1:0] oa, ob, rd, ed;
        logic         obin, rbo, rov, ebo, eov;
        int           lat, sel;
        bit           to;
        for (int i = 0; i < n_vec; i++) begin
            sel = $urandom_range(0, 9);
            oa  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'h8000_0000 : $urandom;
            sel = $urandom_range(0, 9);
            ob  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? oa : $urandom;
            obin = 1'($urandom_range(0, 1));
            run_op(oa, ob, obin, rd, rbo, rov, lat, to);
            model(oa, ob, obin, ed, ebo, eov);
            checks++;
            if (to || rd !== ed || rbo !== ebo || rov !== eov || lat != LATENCY) begin
                errors++;
                $display("FAIL random%0d: a=%h b=%h bin=%b got %h/%b/%b lat=%0d, required %h/%b/%b lat=%0d",
                         i, oa, ob, obin, rd, rbo, rov, lat, ed, ebo, eov, LATENCY);
            end
            $display("random%0d: a=%h b=%h bin=%b diff=%h bout=%b ovf=%b", i, oa, ob, obin, rd, rbo, rov);
            consume($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
